// File: rtl/video_pkg.sv
// ============================================================================
// video_pkg : shared video-pipeline constants (FIFO geometry defaults)
// Rev 1.0
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 256;

    function automatic int fifo_addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dual_fifo_if.sv
// ============================================================================
// dual_fifo_if : write/read handshake bundle of the synchronous FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

interface dual_fifo_if #(
    parameter int WIDTH = video_pkg::FIFO_WIDTH,
    parameter int DEPTH = video_pkg::FIFO_DEPTH
);
    localparam int AW = video_pkg::fifo_addr_width(DEPTH);

    logic [WIDTH-1:0] data;
    logic             wrreq;
    logic             wrfull;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic             rdempty;
    logic [AW:0]      usedw;
    logic             overflow;
    logic             underflow;

    modport master (
        output data, wrreq, rdreq,
        input  wrfull, q, rdempty, usedw, overflow, underflow
    );

    modport slave (
        input  data, wrreq, rdreq,
        output wrfull, q, rdempty, usedw, overflow, underflow
    );

endinterface

`default_nettype wire

// File: rtl/dual_fifo_ram.sv
// ============================================================================
// dual_fifo_ram : simple dual-port RAM, one write port, registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module dual_fifo_ram #(
    parameter int WIDTH = video_pkg::FIFO_WIDTH,
    parameter int DEPTH = video_pkg::FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             we_i,
    input  wire logic [AW-1:0]    waddr_i,
    input  wire logic [WIDTH-1:0] wdata_i,
    input  wire logic             re_i,
    input  wire logic [AW-1:0]    raddr_i,
    output logic      [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register reset maps onto the block-RAM output-latch sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dual_fifo.sv
// ============================================================================
// dual_fifo : single-clock FIFO, normal (non show-ahead) read, over/underflow
// Rev 1.0
// ============================================================================
`default_nettype none

module dual_fifo
    import video_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input wire logic  clk,
    input wire logic  rst,
    dual_fifo_if.slave bus
);

    localparam int          AW         = fifo_addr_width(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      usedw_q, usedw_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, wr_accept, rd_accept;
    logic [WIDTH-1:0] rdata;

    // Flags come only from the registered count, so data never reaches them.
    always_comb begin
        full        = (usedw_q == FULL_COUNT);
        empty       = (usedw_q == '0);
        wr_accept   = bus.wrreq && !full;
        rd_accept   = bus.rdreq && !empty;
        wptr_d      = wr_accept ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = rd_accept ? rptr_q + 1'b1 : rptr_q;
        overflow_d  = bus.wrreq && full;
        underflow_d = bus.rdreq && empty;
        case ({wr_accept, rd_accept})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            usedw_q     <= usedw_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    dual_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_accept),
        .waddr_i (wptr_q),
        .wdata_i (bus.data),
        .re_i    (rd_accept),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

    assign bus.q         = rdata;
    assign bus.wrfull    = full;
    assign bus.rdempty   = empty;
    assign bus.usedw     = usedw_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_fifo.sv
// ============================================================================
// tb_dual_fifo : directed + randomized bench against a queue reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dual_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dual_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dual_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q  = '0;
    logic             exp_ov = 1'b0;
    logic             exp_uf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: model the FIFO rules on the pre-edge state, then compare.
    task automatic step();
        bit               full_pre, empty_pre, wr, rd, r;
        logic [WIDTH-1:0] d;
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() == 0);
        wr = bus.wrreq; rd = bus.rdreq; r = rst; d = bus.data;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_q = '0; exp_ov = 1'b0; exp_uf = 1'b0;
        end else begin
            exp_ov = wr && full_pre;
            exp_uf = rd && empty_pre;
            if (rd && !empty_pre) exp_q = mq.pop_front();
            if (wr && !full_pre)  mq.push_back(d);
        end
        #1;
        chk("q",         32'(bus.q),         32'(exp_q));
        chk("usedw",     32'(bus.usedw),     32'(mq.size()));
        chk("wrfull",    32'(bus.wrfull),    32'(mq.size() == DEPTH));
        chk("rdempty",   32'(bus.rdempty),   32'(mq.size() == 0));
        chk("overflow",  32'(bus.overflow),  32'(exp_ov));
        chk("underflow", 32'(bus.underflow), 32'(exp_uf));
    endtask

    task automatic drive(input bit r, input bit wr, input bit rd, input logic [WIDTH-1:0] d);
        rst = r; bus.wrreq = wr; bus.rdreq = rd; bus.data = d;
        step();
    endtask

    initial begin
        int wp, rp;
        bus.wrreq = 1'b0; bus.rdreq = 1'b0; bus.data = '0;

        // Reset, three writes, three reads
        drive(1, 0, 0, 16'h0);
        for (int i = 1; i <= 3; i++) drive(0, 1, 0, WIDTH'(i));
        for (int i = 0; i < 3; i++)  drive(0, 0, 1, 16'h0);
        drive(0, 0, 0, 16'h0);
        chk("seq3_last_q", 32'(bus.q), 32'h0003);

        // Underflow on empty after reset
        drive(1, 0, 0, 16'h0);
        drive(0, 0, 1, 16'h0);
        chk("uf_pulse", 32'(bus.underflow), 32'd1);
        drive(0, 0, 0, 16'h0);

        // Fill to full, rejected 257th write, drain
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, WIDTH'(i));
        chk("full_flag", 32'(bus.wrfull), 32'd1);
        drive(0, 1, 0, 16'hBEEF);
        chk("ov_pulse", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 16'h0);
        drive(0, 0, 0, 16'h0);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, WIDTH'(16'h1000 + i));
        drive(0, 1, 1, 16'hDEAD);
        chk("full_rw_q", 32'(bus.q), 32'h1000);
        chk("full_rw_usedw", 32'(bus.usedw), 32'd255);
        drive(1, 0, 0, 16'h0);

        // Steady read+write across pointer wrap
        for (int i = 0; i < 10; i++)  drive(0, 1, 0, WIDTH'(i));
        for (int i = 10; i < 310; i++) drive(0, 1, 1, WIDTH'(i));
        chk("wrap_usedw", 32'(bus.usedw), 32'd10);

        // Mid-operation reset with a concurrent write
        drive(1, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, WIDTH'(16'h50 + i));
        drive(1, 1, 0, 16'h77);
        drive(0, 0, 1, 16'h0);
        chk("rst_uf", 32'(bus.underflow), 32'd1);

        // Randomized traffic with biased phases and rare resets
        wp = 60; rp = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin wp = 85; rp = 30; end
                    1:       begin wp = 30; rp = 85; end
                    default: begin wp = 60; rp = 60; end
                endcase
            end
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 99) < wp,
                  $urandom_range(0, 99) < rp,
                  WIDTH'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
